// File: rtl/nand_page_ctrl.sv
// nand_page_ctrl: host-side page controller for a byte-serial NAND flash array.
// Accepts one ERASE / PROGRAM / READ request at a time, buffers a page of
// write data and sequences the flash command bus.
// Optional build macro NAND_CTRL_AUTO_ERASE_EN: PROGRAM erases the target page
// itself (one PRE_ERASE cycle) between the data load and the program burst.
// PAGE_SIZE must be at least 2.
module nand_page_ctrl #(
  parameter int BLOCKS    = 4,
  parameter int PAGES     = 4,
  parameter int PAGE_SIZE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_blk,
  input  logic [7:0] req_page,
  input  logic       wdata_valid,
  output logic       wdata_ready,
  input  logic [7:0] wdata,
  output logic       rdata_valid,
  output logic [7:0] rdata,
  output logic       done,
  output logic       err,
  output logic [1:0] f_cmd,
  output logic [7:0] f_blk,
  output logic [7:0] f_page,
  output logic [7:0] f_din,
  output logic       f_wr_en,
  input  logic [7:0] f_dout,
  input  logic       f_busy
);

  localparam int AW    = $clog2(PAGE_SIZE);
  localparam int CNT_W = AW + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAGE_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PAGE_SIZE);
  localparam logic [8:0]       BLK_LIM  = 9'(BLOCKS);
  localparam logic [8:0]       PAGE_LIM = 9'(PAGES);

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_ERASE = 2'b01;
  localparam logic [1:0] CMD_PROG  = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  localparam logic [1:0] OP_ERASE = 2'b01;
  localparam logic [1:0] OP_PROG  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
`ifdef NAND_CTRL_AUTO_ERASE_EN
    S_PRE_ERASE = 3'd2,
`endif
    S_PROG      = 3'd3,
    S_ERASE     = 3'd4,
    S_READ      = 3'd5,
    S_READ_WAIT = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         f_cmd_q, f_cmd_d;
  logic [7:0]         f_blk_q, f_blk_d;
  logic [7:0]         f_page_q, f_page_d;
  logic [7:0]         f_din_q, f_din_d;
  logic               f_wr_en_q, f_wr_en_d;
  logic               wdata_ready_q, wdata_ready_d;
  logic               rdata_valid_q, rdata_valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;

  logic [7:0]         pbuf_q [PAGE_SIZE];
  logic               buf_we;
  logic               req_legal;
  logic               req_fire;
  logic               wdata_fire;

  assign req_legal  = (req_op != 2'b00) &&
                      ({1'b0, req_blk}  < BLK_LIM) &&
                      ({1'b0, req_page} < PAGE_LIM);
  assign req_ready  = (state_q == S_IDLE) && !f_busy;
  assign req_fire   = req_valid && req_ready;
  assign wdata_fire = wdata_valid && wdata_ready_q;

  assign wdata_ready = wdata_ready_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = f_dout;
  assign done        = done_q;
  assign err         = err_q;
  assign f_cmd       = f_cmd_q;
  assign f_blk       = f_blk_q;
  assign f_page      = f_page_q;
  assign f_din       = f_din_q;
  assign f_wr_en     = f_wr_en_q;

  // Next-state and next-output decode; every flash/handshake output is registered
  always_comb begin
    state_d       = state_q;
    f_cmd_d       = CMD_IDLE;
    f_blk_d       = f_blk_q;
    f_page_d      = f_page_q;
    f_din_d       = f_din_q;
    f_wr_en_d     = 1'b0;
    wdata_ready_d = 1'b0;
    rdata_valid_d = (f_cmd_q == CMD_READ);
    done_d        = 1'b0;
    err_d         = 1'b0;
    wcnt_d        = wcnt_q;
    bcnt_d        = bcnt_q;
    buf_we        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          f_blk_d  = req_blk;
          f_page_d = req_page;
          if (!req_legal) begin
            err_d = 1'b1;
          end else if (req_op == OP_ERASE) begin
            state_d = S_ERASE;
            f_cmd_d = CMD_ERASE;
          end else if (req_op == OP_PROG) begin
            state_d       = S_LOAD;
            wdata_ready_d = 1'b1;
            wcnt_d        = '0;
          end else begin
            state_d = S_READ;
            f_cmd_d = CMD_READ;
            bcnt_d  = CNT_W'(1);
          end
        end
      end

      S_LOAD: begin
        wdata_ready_d = 1'b1;
        if (wdata_fire) begin
          buf_we = 1'b1;
          wcnt_d = wcnt_q + CNT_W'(1);
          if (wcnt_q == CNT_LAST) begin
            wdata_ready_d = 1'b0;
`ifdef NAND_CTRL_AUTO_ERASE_EN
            state_d = S_PRE_ERASE;
            f_cmd_d = CMD_ERASE;
`else
            state_d   = S_PROG;
            f_cmd_d   = CMD_PROG;
            f_wr_en_d = 1'b1;
            f_din_d   = pbuf_q[0];
            bcnt_d    = CNT_W'(1);
`endif
          end
        end
      end

`ifdef NAND_CTRL_AUTO_ERASE_EN
      S_PRE_ERASE: begin
        state_d   = S_PROG;
        f_cmd_d   = CMD_PROG;
        f_wr_en_d = 1'b1;
        f_din_d   = pbuf_q[0];
        bcnt_d    = CNT_W'(1);
      end
`endif

      // bcnt holds the index of the next byte to put on the bus
      S_PROG: begin
        if (bcnt_q == CNT_FULL) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          bcnt_d  = '0;
        end else begin
          f_cmd_d   = CMD_PROG;
          f_wr_en_d = 1'b1;
          f_din_d   = pbuf_q[bcnt_q[AW-1:0]];
          bcnt_d    = bcnt_q + CNT_W'(1);
        end
      end

      S_ERASE: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end

      S_READ: begin
        if (bcnt_q == CNT_FULL) begin
          state_d = S_READ_WAIT;
          bcnt_d  = '0;
        end else begin
          f_cmd_d = CMD_READ;
          bcnt_d  = bcnt_q + CNT_W'(1);
        end
      end

      // Last read byte is returned here, one cycle behind its flash cycle
      S_READ_WAIT: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any burst immediately
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      f_cmd_q       <= CMD_IDLE;
      f_blk_q       <= '0;
      f_page_q      <= '0;
      f_din_q       <= '0;
      f_wr_en_q     <= 1'b0;
      wdata_ready_q <= 1'b0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      wcnt_q        <= '0;
      bcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      f_cmd_q       <= f_cmd_d;
      f_blk_q       <= f_blk_d;
      f_page_q      <= f_page_d;
      f_din_q       <= f_din_d;
      f_wr_en_q     <= f_wr_en_d;
      wdata_ready_q <= wdata_ready_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
      err_q         <= err_d;
      wcnt_q        <= wcnt_d;
      bcnt_q        <= bcnt_d;
    end
  end

  // Page buffer storage: data only, no reset, written once per load byte
  always_ff @(posedge clk) begin
    if (buf_we) begin
      pbuf_q[wcnt_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: doc/nand_page_ctrl.md
# nand_page_ctrl

Host-side page controller that sits directly upstream of the NAND flash array model and owns its command interface. It accepts page-level ERASE / PROGRAM / READ requests over a valid/ready handshake, buffers one page of write data, and sequences the byte-serial flash bus (cmd, blk, page, din, wr_en). On reads it returns the flash byte stream to the host with a valid strobe. Exactly one request is in flight at a time.

## Interface
- BLOCKS, 4, number of flash blocks; legal req_blk is 0..BLOCKS-1
- PAGES, 4, pages per block; legal req_page is 0..PAGES-1
- PAGE_SIZE, 16, bytes per page; page buffer depth and burst length

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  host request present
- req_ready  out  1  controller can accept a request
- req_op  in  2  01=ERASE, 10=PROGRAM, 11=READ; 00 illegal
- req_blk  in  8  target block
- req_page  in  8  target page
- wdata_valid  in  1  write byte present (PROGRAM load phase)
- wdata_ready  out  1  controller accepts write byte
- wdata  in  8  write byte
- rdata_valid  out  1  rdata holds a read byte this cycle
- rdata  out  8  read byte
- done  out  1  one-cycle pulse, request completed
- err  out  1  one-cycle pulse, request rejected
- f_cmd  out  2  flash command (00 idle, 01 erase, 10 program, 11 read)
- f_blk  out  8  flash block address
- f_page  out  8  flash page address
- f_din  out  8  flash write byte
- f_wr_en  out  1  flash write strobe
- f_dout  in  8  flash read byte, valid the cycle after a READ cycle
- f_busy  in  1  flash busy

## Operation
- States: IDLE, LOAD, PRE_ERASE (macro only), PROG, ERASE, READ, READ_WAIT, DONE.
- req_ready = (state==IDLE) && !f_busy. Request accepted on req_valid && req_ready; op/blk/page latched; f_blk/f_page driven from latch until IDLE.
- Reject: op==00, req_blk>=BLOCKS or req_page>=PAGES -> err pulses cycle after acceptance, stay IDLE, f_cmd stays 00.
- ERASE: one cycle f_cmd=01 -> DONE.
- PROGRAM: LOAD with wdata_ready=1; each wdata_valid byte stored at buf[wcnt], wcnt++; after byte PAGE_SIZE-1 -> PROG (or PRE_ERASE). PROG: PAGE_SIZE consecutive cycles f_cmd=10, f_wr_en=1, f_din=buf[0..PAGE_SIZE-1] in order -> DONE.
- READ: PAGE_SIZE consecutive cycles f_cmd=11 -> READ_WAIT (one cycle, f_cmd=00) -> DONE.
- rdata = f_dout (combinational); rdata_valid = registered "f_cmd was 11 last cycle". Exactly PAGE_SIZE rdata_valid cycles per READ; no backpressure.
- DONE: done=1 one cycle, req_ready=0, then IDLE.
- Outside LOAD: wdata_ready=0, wdata_valid ignored. Counters are $clog2(PAGE_SIZE)+1 bits; no wrap inside a burst.
- f_cmd=00, f_wr_en=0 in IDLE, LOAD, READ_WAIT, DONE.

## Timing
- Reset: state IDLE; req_ready=!f_busy; wdata_ready, rdata_valid, done, err, f_wr_en = 0; f_cmd=00; f_blk, f_page, f_din = 0; counters 0. Buffer contents undefined.
- Reset mid-operation aborts immediately; no further flash cycles; partial page not written.
- ERASE latency: accept edge -> f_cmd=01 next cycle -> done the cycle after.
- PROGRAM: PAGE_SIZE load cycles minimum (gaps allowed), then PAGE_SIZE PROG cycles, done next cycle.
- READ: first rdata_valid two cycles after acceptance; last in READ_WAIT; done following cycle.
- f_busy sampled only in IDLE; new request held off while high.

## Configuration
- NAND_CTRL_AUTO_ERASE_EN defined: PROGRAM inserts PRE_ERASE (one cycle, f_cmd=01, same blk/page) between LOAD and PROG; PROGRAM latency +1 cycle.
- Undefined: LOAD goes straight to PROG; host must ERASE first explicitly.

## Test plan
- Reset, then ERASE blk=1 page=2 -> f_cmd=01 for exactly 1 cycle, done 1 cycle later, err never.
- PROGRAM blk=0 page=3 with bytes 0x00..0x0F -> f_wr_en high 16 consecutive cycles, f_din 0x00..0x0F in order; with macro, one f_cmd=01 cycle precedes them.
- READ same page -> 16 rdata_valid cycles, rdata 0x00..0x0F; READ of an erased page -> 16 x 0xFF.
- req_blk=4 (BLOCKS=4) or req_op=00 -> err pulse, no f_cmd activity, req_ready high again next cycle.
- f_busy=1 with req_valid=1 -> req_ready=0, no acceptance until f_busy drops; wdata_valid pulses in IDLE ignored.
- rst_n low after 7 PROGRAM load bytes -> all outputs at reset values next cycle; subsequent READ of that page returns its prior contents.
